// File: rtl/background_subtract_if.sv
// FIFO-facing bundle for background_subtract: two show-ahead input FIFOs and one output FIFO.
interface background_subtract_if;
  logic [7:0] base_dout;
  logic       base_empty;
  logic       base_rd_en;
  logic [7:0] ped_dout;
  logic       ped_empty;
  logic       ped_rd_en;
  logic [7:0] out_din;
  logic       out_full;
  logic       out_wr_en;
  logic       frame_done;

  modport master (
    input  base_dout, base_empty, ped_dout, ped_empty, out_full,
    output base_rd_en, ped_rd_en, out_din, out_wr_en, frame_done
  );

  modport slave (
    output base_dout, base_empty, ped_dout, ped_empty, out_full,
    input  base_rd_en, ped_rd_en, out_din, out_wr_en, frame_done
  );
endinterface

// File: rtl/background_subtract.sv
// Motion mask from |current - background| gray difference, one pixel per read/write pair.
// Holds at most one pixel (the registered mask) between the input pop and the output write.
module background_subtract #(
  parameter int         WIDTH     = 768,
  parameter int         HEIGHT    = 576,
  parameter logic [7:0] THRESHOLD = 8'd50
) (
  input  logic                  clock,
  input  logic                  reset,
  background_subtract_if.master bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  typedef enum logic {S_READ = 1'b0, S_WRITE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mask_q, mask_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop, push;
  logic signed [8:0] diff_s, diff_n;
  logic [7:0]      diff;

  // Both FIFOs pop together or not at all; reset masks every strobe.
  assign pop  = !reset && (state_q == S_READ)  && !bus.base_empty && !bus.ped_empty;
  assign push = !reset && (state_q == S_WRITE) && !bus.out_full;

  always_comb begin
    diff_s = $signed({1'b0, bus.ped_dout}) - $signed({1'b0, bus.base_dout});
    diff_n = -diff_s;
    diff   = diff_s[8] ? diff_n[7:0] : diff_s[7:0];
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_READ: begin
        if (pop) begin
          mask_d  = (diff > THRESHOLD) ? 8'hFF : 8'h00;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (push) begin
          state_d = S_READ;
          cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_READ;
      mask_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.base_rd_en = pop;
  assign bus.ped_rd_en  = pop;
  assign bus.out_wr_en  = push;
  assign bus.out_din    = reset ? 8'h00 : mask_q;
  assign bus.frame_done = push && (cnt_q == LAST);
endmodule

// File: tb/tb_background_subtract.sv
// Self-checking bench for background_subtract (4x2 frame): directed vectors, stall/reset corners, random scoreboard.
module tb_background_subtract;
  localparam int W = 4, H = 2, NPIX = W * H, TH = 50, NRND = 150;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  background_subtract_if bgi ();
  background_subtract #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(8'(TH))) dut (
    .clock(clk), .reset(rst), .bus(bgi)
  );

  typedef struct {logic [7:0] b; logic [7:0] p; logic [7:0] m;} vec_t;
  vec_t vecs[9];

  int checks = 0, errors = 0, wr_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit be, input bit pe, input logic [7:0] b, input logic [7:0] p, input bit full);
    bgi.base_empty = be; bgi.ped_empty = pe;
    bgi.base_dout  = b;  bgi.ped_dout  = p;
    bgi.out_full   = full;
  endtask

  task automatic adv();    @(posedge clk); #1; endtask
  task automatic settle(); @(negedge clk);     endtask

  function automatic logic [7:0] ref_mask(input logic [7:0] b, input logic [7:0] p);
    int d;
    d = int'(p) - int'(b);
    if (d < 0) d = -d;
    return (d > TH) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic exp_fd();
    return (wr_count % NPIX) == NPIX - 1;
  endfunction

  task automatic check_write(input string nm, input logic [7:0] m);
    chk({nm, " wr"}, 32'(bgi.out_wr_en), 32'd1);
    chk({nm, " din"}, 32'(bgi.out_din), 32'(m));
    chk({nm, " fd"}, 32'(bgi.frame_done), 32'(exp_fd()));
    wr_count++;
  endtask

  task automatic pair(input string nm, input logic [7:0] b, input logic [7:0] p, input logic [7:0] m);
    set_in(1'b0, 1'b0, b, p, 1'b0);
    settle; chk({nm, " pop"}, 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd3);
    adv; set_in(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    settle; check_write(nm, m);
    adv;
  endtask

  logic [7:0] bq[$], pq[$], eq[$];

  initial begin
    vecs[0] = '{8'h10, 8'h80, 8'hFF};
    vecs[1] = '{8'h80, 8'h4E, 8'h00};
    vecs[2] = '{8'h80, 8'h4D, 8'hFF};
    vecs[3] = '{8'h00, 8'hFF, 8'hFF};
    vecs[4] = '{8'h80, 8'h80, 8'h00};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF};
    vecs[6] = '{8'h40, 8'h72, 8'h00};
    vecs[7] = '{8'h72, 8'h40, 8'h00};
    vecs[8] = '{8'h40, 8'h73, 8'hFF};

    // reset with both FIFOs offering data: nothing may move
    set_in(1'b0, 1'b0, 8'h10, 8'h80, 1'b0);
    adv; adv;
    settle;
    chk("rst rd", 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd0);
    chk("rst wr", 32'(bgi.out_wr_en), 32'd0);
    chk("rst fd", 32'(bgi.frame_done), 32'd0);
    chk("rst din", 32'(bgi.out_din), 32'd0);
    adv; rst = 1'b0; set_in(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    settle; chk("idle wr", 32'(bgi.out_wr_en), 32'd0);
    adv;

    for (int i = 0; i < 9; i++)
      pair($sformatf("vec%0d", i), vecs[i].b, vecs[i].p, vecs[i].m);

    // ped FIFO empty: no pops and no writes until it fills
    set_in(1'b0, 1'b1, 8'h10, 8'h80, 1'b0);
    for (int i = 0; i < 10; i++) begin
      settle;
      chk("halfempty rd", 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd0);
      chk("halfempty wr", 32'(bgi.out_wr_en), 32'd0);
      adv;
    end
    set_in(1'b0, 1'b0, 8'h10, 8'h80, 1'b0);
    settle; chk("halfempty pop", 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd3);
    adv;

    // output full with both inputs ready: hold everything
    set_in(1'b0, 1'b0, 8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("full wr", 32'(bgi.out_wr_en), 32'd0);
      chk("full rd", 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd0);
      chk("full din", 32'(bgi.out_din), 32'hFF);
      adv;
    end
    set_in(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    settle; check_write("unfull", 8'hFF);
    adv;
    set_in(1'b0, 1'b0, 8'h80, 8'h4E, 1'b0);
    settle;
    chk("resume wr", 32'(bgi.out_wr_en), 32'd0);
    chk("resume rd", 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd3);
    adv; set_in(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    settle; check_write("resume", 8'h00);
    adv;

    // reset while a mask waits on a full output FIFO
    set_in(1'b0, 1'b0, 8'h00, 8'hFF, 1'b0);
    settle; chk("prerst pop", 32'({bgi.base_rd_en, bgi.ped_rd_en}), 32'd3);
    adv; set_in(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
    settle; chk("prerst wr", 32'(bgi.out_wr_en), 32'd0);
    adv; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle;
      chk("midrst wr", 32'(bgi.out_wr_en), 32'd0);
      chk("midrst fd", 32'(bgi.frame_done), 32'd0);
      chk("midrst din", 32'(bgi.out_din), 32'd0);
      adv;
    end
    rst = 1'b0; set_in(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    wr_count = 0;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("postrst wr", 32'(bgi.out_wr_en), 32'd0);
      chk("postrst din", 32'(bgi.out_din), 32'd0);
      adv;
    end
    pair("postrst", 8'h80, 8'h4D, 8'hFF);

    // random traffic against an ordered scoreboard
    for (int i = 0; i < NRND; i++) begin
      logic [7:0] b, p;
      b = 8'($urandom_range(0, 255));
      if (i % 2 == 0) p = 8'($urandom_range(0, 255));
      else begin
        int t;
        t = int'(b) + (($urandom_range(0, 1) == 1) ? 1 : -1) * int'($urandom_range(TH - 4, TH + 4));
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        p = 8'(t);
      end
      bq.push_back(b); pq.push_back(p); eq.push_back(ref_mask(b, p));
    end
    begin
      int written = 0;
      bit pending = 0;
      for (int cyc = 0; cyc < 4000 && written < NRND; cyc++) begin
        bit bv, pv, full, rdb, rdp, wr;
        bv   = (bq.size() > 0) && ($urandom_range(0, 3) != 0);
        pv   = (pq.size() > 0) && ($urandom_range(0, 3) != 0);
        full = ($urandom_range(0, 2) == 0);
        set_in(!bv, !pv, bv ? bq[0] : 8'($urandom), pv ? pq[0] : 8'($urandom), full);
        settle;
        rdb = bgi.base_rd_en; rdp = bgi.ped_rd_en; wr = bgi.out_wr_en;
        chk("rnd lockstep", 32'(rdb), 32'(rdp));
        chk("rnd rd", 32'(rdb), 32'(!pending && bv && pv));
        chk("rnd wr", 32'(wr), 32'(pending && !full));
        if (wr && eq.size() > 0) begin
          chk("rnd din", 32'(bgi.out_din), 32'(eq[0]));
          chk("rnd fd", 32'(bgi.frame_done), 32'(exp_fd()));
          void'(eq.pop_front());
          wr_count++; written++; pending = 0;
        end else if (!wr) begin
          chk("rnd nofd", 32'(bgi.frame_done), 32'd0);
        end
        if (rdb && bv && pv) begin
          void'(bq.pop_front()); void'(pq.pop_front());
          pending = 1;
        end
        adv;
      end
      chk("rnd all written", 32'(written), 32'(NRND));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/background_subtract.md
BACKGROUND_SUBTRACT -- requirements
Module: background_subtract

Interface
REQ-001 SHALL have parameter WIDTH, default 768, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 576, frame height in pixels.
REQ-003 SHALL have parameter THRESHOLD, default 50, 8-bit motion threshold on absolute gray difference.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port base_dout  input  8  background gray pixel from show-ahead FIFO; valid while base_empty=0.
REQ-007 SHALL have port base_empty  input  1  background FIFO empty.
REQ-008 SHALL have port base_rd_en  output  1  pops background FIFO.
REQ-009 SHALL have port ped_dout  input  8  current-frame gray pixel from show-ahead FIFO; valid while ped_empty=0.
REQ-010 SHALL have port ped_empty  input  1  current-frame FIFO empty.
REQ-011 SHALL have port ped_rd_en  output  1  pops current-frame FIFO.
REQ-012 SHALL have port out_din  output  8  mask pixel to output FIFO: 0xFF motion, 0x00 static.
REQ-013 SHALL have port out_full  input  1  output FIFO full.
REQ-014 SHALL have port out_wr_en  output  1  writes out_din into output FIFO.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse on write of last pixel of a frame.

Function
REQ-016 SHALL implement two states: S_READ and S_WRITE.
REQ-017 In S_READ, SHALL assert base_rd_en and ped_rd_en together, combinationally, only when base_empty=0 and ped_empty=0; else both 0.
REQ-018 SHALL never pop one input FIFO without the other (lockstep pairing).
REQ-019 On a pop in S_READ, SHALL compute diff = |ped_dout - base_dout| in 9-bit signed arithmetic, result 8-bit unsigned, range 0..255.
REQ-020 SHALL register mask = 0xFF when diff > THRESHOLD (strict), else 0x00, and move to S_WRITE at that clock edge.
REQ-021 In S_WRITE, SHALL assert out_wr_en combinationally when out_full=0, with out_din = registered mask; return to S_READ at that edge.
REQ-022 In S_WRITE with out_full=1, SHALL hold state, hold mask, keep out_wr_en=0, and assert no rd_en.
REQ-023 out_din SHALL always equal the mask register (held between writes).
REQ-024 SHALL keep a pixel counter, width ceil(log2(WIDTH*HEIGHT)), incremented on each out_wr_en.
REQ-025 When out_wr_en=1 and counter = WIDTH*HEIGHT-1, SHALL assert frame_done that cycle and wrap counter to 0.
REQ-026 Latency: pop to out_wr_en SHALL be exactly 1 cycle when out_full=0; peak throughput one pixel per 2 cycles.
REQ-027 One input empty, other non-empty: SHALL stay in S_READ, no pops, no output change.
REQ-028 out_full SHALL be ignored in S_READ; base_empty/ped_empty SHALL be ignored in S_WRITE.
REQ-029 SHALL contain no other storage; no pixel dropped, duplicated, or reordered.

Reset
REQ-030 On reset=1 at a rising edge, SHALL enter S_READ, clear mask to 0x00 and counter to 0.
REQ-031 While reset=1, base_rd_en, ped_rd_en, out_wr_en, frame_done SHALL be 0 and out_din 0x00.
REQ-032 Reset mid-operation (in S_WRITE) SHALL discard the pending mask; no write of it after reset release.
REQ-033 First pop after reset release SHALL occur no earlier than the first cycle with reset=0 and both FIFOs non-empty.

Verification
REQ-034 base=0x10, ped=0x80, THRESHOLD=50 -> one cycle after paired pop, out_wr_en=1, out_din=0xFF.
REQ-035 base=0x80, ped=0x4E (diff 50) -> out_din=0x00; base=0x80, ped=0x4D (diff 51) -> 0xFF; base=0x00, ped=0xFF -> 0xFF.
REQ-036 base_empty=0, ped_empty=1 for 10 cycles -> no rd_en, no write; ped_empty drops -> paired pop next cycle.
REQ-037 out_full=1 for 5 cycles in S_WRITE -> no write, no pops, out_din stable; out_full=0 -> single write, then resume reads.
REQ-038 WIDTH=4, HEIGHT=2, stream 16 pixel pairs -> 16 writes, frame_done pulses on writes 8 and 16 only.
REQ-039 Assert reset in S_WRITE with out_full=1 -> after release, outputs 0, counter 0, first write carries next popped pair's mask.
